uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- Serial UART receiver that sits directly upstream of the CPU control path.
- Turns the asynchronous RX line into 8-bit bytes (8N1, LSB first).
- For each good byte it raises a one-cycle byte_ready strobe, which the control path uses to write the byte into RAM[0x7FF] and redirect the PC to 0x7F6.
- rx_data holds the last good byte so the datapath can read it while the RAM write is in progress.

Parameters:
- CLK_DIV, 434, system clock cycles per bit period (50 MHz / 115200). Integer ≥ 4. HALF = CLK_DIV >> 1.
- CNT_W, $clog2(CLK_DIV), width of the bit-period counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line. Idles high. Asynchronous to clk.
- rx_data  output  8  last correctly framed byte. Stable between byte_ready strobes.
- byte_ready  output  1  one-cycle pulse when a byte with a valid stop bit completes.
- frame_error  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: clk and rst as listed above; reset is asynchronous and active-high.
  - Async-clear the synchronizer FFs s1 and s2 to 1.
  - Clear state to IDLE; clear counter, bit_idx and shift register to 0.
  - Clear rx_data to 0x00, byte_ready to 0, frame_error to 0, busy to 0.
  - Reset asserted mid-frame aborts the frame: no strobe, rx_data keeps 0x00.
- Synchronizer: rx → s1 → s2. All decisions use s2 only. This adds 2 cycles of input latency.
- IDLE:
  - If s2 = 0, go to START with cnt = 0.
  - Otherwise stay.
- START (verify the start bit at mid-bit):
  - cnt increments each cycle.
  - When cnt = HALF−1, sample s2:
    - s2 = 0: go to DATA with cnt = 0 and bit_idx = 0.
    - s2 = 1: false start (glitch); go to IDLE with no output activity.
- DATA:
  - cnt counts 0..CLK_DIV−1.
  - At cnt = CLK_DIV−1: shift = {s2, shift[7:1]} (LSB first), cnt = 0, bit_idx += 1.
  - After the sample taken with bit_idx = 7, go to STOP.
- STOP:
  - At cnt = CLK_DIV−1, sample s2:
    - s2 = 1: rx_data ← shift, byte_ready = 1 for exactly the next cycle, go to IDLE.
    - s2 = 0: frame_error = 1 for exactly the next cycle, rx_data unchanged, go to BREAK.
- BREAK:
  - Wait until s2 = 1, then go to IDLE.
  - A held-low line (break) yields exactly one frame_error, not repeated frames.
- Outputs are registered:
  - byte_ready and frame_error are never high together.
  - Neither is ever high for more than one cycle.
- Sample timing:
  - Samples land at mid-bit: HALF cycles after the detected falling edge, then every CLK_DIV cycles.
  - Latency from the s2 falling edge to the byte_ready high cycle is HALF + 9·CLK_DIV + 1 cycles.
- Back-to-back frames:
  - STOP returns to IDLE at mid-stop-bit.
  - A start bit immediately following the stop bit is detected, with no lost frames at the nominal rate.
- Counters:
  - cnt is CNT_W bits and never wraps (it is compared and cleared explicitly).
  - bit_idx is 3 bits.
- busy:
  - High in START, DATA, STOP and BREAK.
  - Low in IDLE.
  - Drops in the same cycle that byte_ready rises.
- No flow control:
  - A new byte overwrites rx_data at its strobe.
  - The consumer must take rx_data within one frame time.

Test Plan:
- Send 0xA5 (CLK_DIV = 8, 8N1) → byte_ready high for exactly one cycle, 4 + 72 + 1 cycles after the s2 falling edge; rx_data = 0xA5 thereafter; frame_error stays 0.
- Send 0x55 then 0x0F back-to-back with no idle bits → two byte_ready pulses 80 cycles apart; rx_data = 0x55, then 0x0F.
- Drive rx low for 2 cycles, then high (CLK_DIV = 8) → busy pulses and returns to 0; no byte_ready, no frame_error; state back in IDLE.
- Send 0x3C with the stop bit forced low, then hold rx low for 40 cycles, then release → exactly one frame_error pulse; rx_data keeps its previous value; the next valid byte 0x81 is received correctly.
- Assert rst during data bit 4 of 0xFF → all outputs 0 immediately (async); no strobe; a following byte 0x12 is received as 0x12.
- Send 0x00 and 0xFF with CLK_DIV = 4 → rx_data = 0x00, then 0xFF; each with exactly one byte_ready pulse.

Source files
------------

// File: rtl/uart_rx_byte.sv
`timescale 1ns/1ps
// UART 8N1 receiver: recovers LSB-first bytes from an asynchronous rx line.
// Latency: 2-cycle synchronizer, then HALF + 9*CLK_DIV + 1 cycles from falling edge to byte_ready.
// No backpressure: each good byte overwrites rx_data at its strobe; consumer must keep up.
module uart_rx_byte #(
  parameter int CLK_DIV = 434,
  parameter int CNT_W   = $clog2(CLK_DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       byte_ready,
  output logic       frame_error,
  output logic       busy
);

  localparam int HALF = CLK_DIV >> 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  logic             s1, s2;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       rx_data_n;
  logic             byte_ready_n, frame_error_n;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data     <= '0;
      byte_ready  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      rx_data     <= rx_data_n;
      byte_ready  <= byte_ready_n;
      frame_error <= frame_error_n;
    end
  end

  // Next-state logic: verify start at mid-bit, then sample every CLK_DIV cycles.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    bit_idx_n     = bit_idx;
    shift_n       = shift;
    rx_data_n     = rx_data;
    byte_ready_n  = 1'b0;
    frame_error_n = 1'b0;
    case (state)
      IDLE: begin
        if (!s2) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == CNT_MID) begin
          cnt_n = '0;
          if (!s2) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shift_n   = {s2, shift[7:1]};
          cnt_n     = '0;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (s2) begin
            rx_data_n    = shift;
            byte_ready_n = 1'b1;
            state_n      = IDLE;
          end else begin
            frame_error_n = 1'b1;
            state_n       = BRK;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      BRK: begin
        // Hold here until the line recovers so a break reports only once.
        if (s2) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
`timescale 1ns/1ps
// Bench for uart_rx_byte: two instances (CLK_DIV 8 and 4) on a shared clock and reset.
// Directed latency/back-to-back/glitch/reset sequences, a vector table, and random frames.
// Expected bytes come from the frame contents: good stop gives the byte, low stop gives one error.
module tb_uart_rx_byte;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx8 = 1'b1;
  logic       rx4 = 1'b1;
  logic [7:0] d8, d4;
  logic       br8, fe8, bz8, br4, fe4, bz4;

  uart_rx_byte #(.CLK_DIV(8)) u8 (
    .clk(clk), .rst(rst), .rx(rx8), .rx_data(d8),
    .byte_ready(br8), .frame_error(fe8), .busy(bz8)
  );
  uart_rx_byte #(.CLK_DIV(4)) u4 (
    .clk(clk), .rst(rst), .rx(rx4), .rx_data(d4),
    .byte_ready(br4), .frame_error(fe4), .busy(bz4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    logic [7:0] dat;
    int         cyc;
  } ev_t;

  ev_t ev8[$];
  ev_t ev4[$];
  int  viol8 = 0, viol4 = 0;
  logic pbr8 = 1'b0, pfe8 = 1'b0, pbr4 = 1'b0, pfe4 = 1'b0;
  logic [7:0] pd8 = 8'h00, pd4 = 8'h00;

  // Record every strobe and flag protocol breaks on the CLK_DIV=8 instance.
  always @(negedge clk) begin
    if (br8 || fe8) ev8.push_back('{ferr: fe8, dat: d8, cyc: cyc});
    if ((br8 && fe8) || (br8 && pbr8) || (fe8 && pfe8) || (br8 && bz8)) viol8++;
    if (!rst && !br8 && (d8 !== pd8)) viol8++;
    pbr8 = br8;
    pfe8 = fe8;
    pd8  = d8;
  end

  // Same monitor for the CLK_DIV=4 instance.
  always @(negedge clk) begin
    if (br4 || fe4) ev4.push_back('{ferr: fe4, dat: d4, cyc: cyc});
    if ((br4 && fe4) || (br4 && pbr4) || (fe4 && pfe4) || (br4 && bz4)) viol4++;
    if (!rst && !br4 && (d4 !== pd4)) viol4++;
    pbr4 = br4;
    pfe4 = fe4;
    pd4  = d4;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold the selected line at v for n cycles (called at a falling clock edge).
  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx4 = v;
    else     rx8 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input logic stop);
    int d = sel ? 4 : 8;
    drive(sel, 1'b0, d);
    for (int i = 0; i < 8; i++) drive(sel, b[i], d);
    drive(sel, stop, d);
  endtask

  typedef struct {
    logic [7:0] dat;
    bit         stop;
    int         hold;
    bit         exp_ferr;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t       tbl[4];
  int         base, t0, n;
  bit         seen;
  ev_t        e;
  logic [7:0] rb;
  bit         rstop;
  ev_t        expq[$];
  logic [7:0] last;

  initial begin
    tbl[0] = '{dat: 8'h3C, stop: 1'b0, hold: 40, exp_ferr: 1'b1, exp_rx: 8'h0F};
    tbl[1] = '{dat: 8'h81, stop: 1'b1, hold: 0,  exp_ferr: 1'b0, exp_rx: 8'h81};
    tbl[2] = '{dat: 8'hC3, stop: 1'b1, hold: 0,  exp_ferr: 1'b0, exp_rx: 8'hC3};
    tbl[3] = '{dat: 8'h7E, stop: 1'b0, hold: 0,  exp_ferr: 1'b1, exp_rx: 8'hC3};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rx_data8", 32'(d8), 32'h0);
    chk("rst_flags8", 32'({br8, fe8, bz8}), 32'h0);
    chk("rst_rx_data4", 32'(d4), 32'h0);
    chk("rst_flags4", 32'({br4, fe4, bz4}), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0xA5: 2 sync cycles + HALF + 9*CLK_DIV + 1 = 79 cycles from rx falling
    base = ev8.size();
    t0   = cyc;
    send(1'b0, 8'hA5, 1'b1);
    drive(1'b0, 1'b1, 16);
    chk("a5_count", 32'(ev8.size() - base), 32'd1);
    if (ev8.size() > base) begin
      chk("a5_data", 32'(ev8[base].dat), 32'hA5);
      chk("a5_ferr", 32'(ev8[base].ferr), 32'h0);
      chk("a5_latency", 32'(ev8[base].cyc - t0), 32'd79);
    end
    chk("a5_rx_data", 32'(d8), 32'hA5);

    // Back-to-back 0x55, 0x0F with no idle bits
    base = ev8.size();
    send(1'b0, 8'h55, 1'b1);
    send(1'b0, 8'h0F, 1'b1);
    drive(1'b0, 1'b1, 16);
    chk("b2b_count", 32'(ev8.size() - base), 32'd2);
    if (ev8.size() >= base + 2) begin
      chk("b2b_first", 32'(ev8[base].dat), 32'h55);
      chk("b2b_second", 32'(ev8[base+1].dat), 32'h0F);
      chk("b2b_spacing", 32'(ev8[base+1].cyc - ev8[base].cyc), 32'd80);
    end
    chk("b2b_rx_data", 32'(d8), 32'h0F);

    // 2-cycle glitch: busy pulses, nothing reported
    base = ev8.size();
    drive(1'b0, 1'b0, 2);
    rx8  = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bz8) seen = 1'b1;
    end
    chk("glitch_busy_seen", 32'(seen), 32'h1);
    chk("glitch_busy_end", 32'(bz8), 32'h0);
    chk("glitch_events", 32'(ev8.size() - base), 32'd0);

    // Vector table: framing errors and recovery
    for (int i = 0; i < 4; i++) begin
      base = ev8.size();
      send(1'b0, tbl[i].dat, tbl[i].stop);
      if (!tbl[i].stop) drive(1'b0, 1'b0, tbl[i].hold);
      drive(1'b0, 1'b1, 24);
      chk($sformatf("vec%0d_count", i), 32'(ev8.size() - base), 32'd1);
      if (ev8.size() > base) begin
        chk($sformatf("vec%0d_ferr", i), 32'(ev8[base].ferr), 32'(tbl[i].exp_ferr));
        if (!tbl[i].exp_ferr)
          chk($sformatf("vec%0d_data", i), 32'(ev8[base].dat), 32'(tbl[i].dat));
      end
      chk($sformatf("vec%0d_rx_data", i), 32'(d8), 32'(tbl[i].exp_rx));
    end

    // Reset during data bit 4 of 0xFF
    base = ev8.size();
    drive(1'b0, 1'b0, 8);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8);
    drive(1'b0, 1'b1, 4);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rx_data", 32'(d8), 32'h0);
    chk("midrst_flags", 32'({br8, fe8, bz8}), 32'h0);
    @(negedge clk);
    rx8 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 24);
    chk("midrst_no_strobe", 32'(ev8.size() - base), 32'd0);
    chk("midrst_rx_kept", 32'(d8), 32'h0);
    send(1'b0, 8'h12, 1'b1);
    drive(1'b0, 1'b1, 16);
    chk("after_rst_count", 32'(ev8.size() - base), 32'd1);
    chk("after_rst_rx_data", 32'(d8), 32'h12);

    // CLK_DIV = 4: 0x00 then 0xFF
    base = ev4.size();
    send(1'b1, 8'h00, 1'b1);
    drive(1'b1, 1'b1, 8);
    chk("div4_00_count", 32'(ev4.size() - base), 32'd1);
    chk("div4_00_rx_data", 32'(d4), 32'h00);
    send(1'b1, 8'hFF, 1'b1);
    drive(1'b1, 1'b1, 8);
    chk("div4_ff_count", 32'(ev4.size() - base), 32'd2);
    chk("div4_ff_rx_data", 32'(d4), 32'hFF);

    // Random frames on both instances against the frame-level model
    for (int sel = 0; sel < 2; sel++) begin
      int d = (sel != 0) ? 4 : 8;
      base = (sel != 0) ? ev4.size() : ev8.size();
      last = (sel != 0) ? 8'hFF : 8'h12;
      expq.delete();
      for (int k = 0; k < 30; k++) begin
        rb    = 8'($urandom);
        rstop = ($urandom_range(0, 4) != 0);
        send(sel[0], rb, rstop);
        expq.push_back('{ferr: !rstop, dat: rb, cyc: 0});
        if (rstop) last = rb;
        if (!rstop) begin
          drive(sel[0], 1'b0, $urandom_range(0, 3 * d));
          drive(sel[0], 1'b1, d + $urandom_range(0, d));
        end else if ($urandom_range(0, 1) != 0) begin
          drive(sel[0], 1'b1, $urandom_range(1, 2 * d));
        end
      end
      drive(sel[0], 1'b1, 3 * d);
      n = ((sel != 0) ? ev4.size() : ev8.size()) - base;
      chk($sformatf("rand%0d_count", d), 32'(n), 32'(expq.size()));
      for (int k = 0; k < expq.size() && k < n; k++) begin
        e = (sel != 0) ? ev4[base+k] : ev8[base+k];
        chk($sformatf("rand%0d_ferr_%0d", d, k), 32'(e.ferr), 32'(expq[k].ferr));
        if (!expq[k].ferr)
          chk($sformatf("rand%0d_data_%0d", d, k), 32'(e.dat), 32'(expq[k].dat));
      end
      chk($sformatf("rand%0d_rx_data", d), 32'((sel != 0) ? d4 : d8), 32'(last));
    end

    chk("protocol8", 32'(viol8), 32'd0);
    chk("protocol4", 32'(viol4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
